ucode_sequencer: RTL and testbench
==================================

UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 Parameter ADDR_W, default 6: microcode address width; must be at least 7 when dispatch indices exceed the ROM range.
REQ-002 Parameter CTRL_W, default 16: width of the control field delivered to the datapath.
REQ-003 Parameter STACK_DEPTH, default 4: call/return stack entries; minimum 1.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: reset, asynchronous, active-high.
REQ-006 Port stall, input, 1: freezes all sequencer state while high.
REQ-007 Port op, input, 2: instruction opcode field used for dispatch.
REQ-008 Port funct, input, 6: instruction funct field used for dispatch.
REQ-009 Port cond_true, input, 1: condition result used by the BRANCH mode.
REQ-010 Port uaddr, output, ADDR_W: microcode ROM address, equal to upc.
REQ-011 Port uword, input, CTRL_W+ADDR_W+3: ROM data with layout {ctrl, target, mode[2:0]}, mode in the LSBs.
REQ-012 Port ctrl, output, CTRL_W: registered control field.
REQ-013 Port instr_done, output, 1: high while the registered microword's mode is FETCH.
REQ-014 Port seq_err, output, 1: sticky sequencing-error flag.
REQ-015 Port stack_level, output, $clog2(STACK_DEPTH+1): current stack occupancy.

Function
REQ-016 Per rising edge with stall low: uword_q <= uword; upc <= next address computed from uword.mode and uword.target, relative to the current upc.
REQ-017 ctrl = uword_q control field; ctrl lags uaddr by exactly one cycle; throughput one microword per cycle.
REQ-018 Mode 0 SEQ: next = upc+1, wrapping modulo 2^ADDR_W.
REQ-019 Mode 1 JUMP: next = target.
REQ-020 Mode 2 BRANCH: next = target if cond_true, else upc+1.
REQ-021 Mode 3 DISPATCH: next = target + {op, funct[5], funct[4], funct[2], funct[0]}, modulo 2^ADDR_W; op and funct are sampled at that edge.
REQ-022 Mode 4 CALL: push upc+1 and set next = target; on a full stack, no push occurs, the jump still occurs, and seq_err is set.
REQ-023 Mode 5 RETURN: pop and set next = top of stack; on an empty stack, next = 0 and seq_err is set.
REQ-024 Mode 6 FETCH: next = 0.
REQ-025 Mode 7 (reserved): treated as FETCH and sets seq_err.
REQ-026 With stall high, upc, uword_q, the stack, stack_level and seq_err all hold, and ctrl stays constant.
REQ-027 seq_err is cleared only by reset.

Reset
REQ-028 On reset assertion, immediately: upc=0, uword_q=0 (ctrl=0, instr_done=0), stack_level=0, seq_err=0.
REQ-029 Reset asserted mid-subroutine discards all stack contents; the first post-reset edge latches the word at address 0.

Configuration
REQ-030 Macro UCODE_STACK_EN defined: CALL and RETURN behave per REQ-022 and REQ-023.
REQ-031 Macro UCODE_STACK_EN undefined: no stack storage is built; CALL behaves as JUMP; RETURN behaves as FETCH and sets seq_err; stack_level is tied to 0.

Structure
REQ-032 Package ucode_pkg holds the mode enum (SEQ, JUMP, BRANCH, DISPATCH, CALL, RETURN, FETCH, RSVD), the MODE_W=3 constant, and the dispatch-index width constant of 6.
REQ-033 The stack is implemented as sub-module ucode_stack (push, pop, full, empty, level) and is instantiated only under UCODE_STACK_EN.
REQ-034 The microcode ROM is external to this block.

Verification
REQ-035 Reset, then ROM returns SEQ at addresses 0..2 -> uaddr 0,1,2,3 on successive cycles; ctrl equals word0.ctrl one cycle after uaddr=0.
REQ-036 Dispatch: at addr 0, DISPATCH with target=8, op=2'b01, funct=6'b100001 (index 6'b011001=25) -> next uaddr=33.
REQ-037 Branch: BRANCH with target=20 at addr 5; cond_true=1 -> uaddr 20; cond_true=0 -> uaddr 6.
REQ-038 Stack (UCODE_STACK_EN, STACK_DEPTH=4): CALL at 3 to 10, then RETURN at 10 -> uaddr 4, with stack_level going 0->1->0; five nested CALLs -> stack_level stays 4 and seq_err=1; RETURN on an empty stack -> uaddr 0 and seq_err=1.
REQ-039 Stall: raise stall for 3 cycles during a SEQ run -> uaddr, ctrl and stack_level are unchanged; the sequence resumes at the next address.
REQ-040 Wrap and reset: SEQ at address 63 (ADDR_W=6) -> uaddr 0; reset asserted between edges mid-CALL -> ctrl=0, stack_level=0 and uaddr=0 without waiting for a clock edge.

Source files
------------

// File: rtl/ucode_pkg.sv
// Shared types and constants for the microcode sequencer: microword modes
// and the width of the instruction dispatch index.
package ucode_pkg;

    localparam int MODE_W = 3;
    localparam int DISP_W = 6;

    typedef enum logic [MODE_W-1:0] {
        SEQ      = 3'd0,
        JUMP     = 3'd1,
        BRANCH   = 3'd2,
        DISPATCH = 3'd3,
        CALL     = 3'd4,
        RETURN   = 3'd5,
        FETCH    = 3'd6,
        RSVD     = 3'd7
    } mode_e;

endpackage

// File: rtl/ucode_stack.sv
// Call/return address stack for the microcode sequencer. Pushes on a full
// stack and pops on an empty stack are ignored; the caller flags the error.
module ucode_stack
    import ucode_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          pushData,
    output logic [DATA_W-1:0]          top,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  wrIdx;
    logic [IDX_W-1:0]  rdIdx;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign wrIdx = IDX_W'(level);
    assign rdIdx = IDX_W'(level - LVL_W'(1));
    assign top   = mem[rdIdx];

    // Only the occupancy is reset; stale entries above it are never read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= '0;
        end else if (push && !full) begin
            level <= level + LVL_W'(1);
        end else if (pop && !empty) begin
            level <= level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wrIdx] <= pushData;
        end
    end

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: computes the next ROM address from the fetched
// microword and registers its control field. Define UCODE_STACK_EN to build
// the call/return stack; without it CALL acts as JUMP and RETURN as an error.
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int CTRL_W      = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic [1:0]                       op,
    input  logic [5:0]                       funct,
    input  logic                             cond_true,
    output logic [ADDR_W-1:0]                uaddr,
    input  logic [CTRL_W+ADDR_W+MODE_W-1:0]  uword,
    output logic [CTRL_W-1:0]                ctrl,
    output logic                             instr_done,
    output logic                             seq_err,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level
);

    mode_e             mode;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] upc;
    logic [ADDR_W-1:0] seqPc;
    logic [ADDR_W-1:0] nextPc;
    logic [DISP_W-1:0] dispIdx;
    logic              errSet;
    logic              unusedFunct;
    logic [CTRL_W-1:0] ctrl_p1;
    mode_e             mode_p1;

    assign mode        = mode_e'(uword[MODE_W-1:0]);
    assign target      = uword[MODE_W +: ADDR_W];
    assign dispIdx     = {op, funct[5], funct[4], funct[2], funct[0]};
    assign unusedFunct = funct[3] ^ funct[1];
    assign uaddr       = upc;

`ifdef UCODE_STACK_EN
    logic              doPush;
    logic              doPop;
    logic              stkFull;
    logic              stkEmpty;
    logic [ADDR_W-1:0] stkTop;

    ucode_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (doPush && !stall),
        .pop      (doPop && !stall),
        .pushData (seqPc),
        .top      (stkTop),
        .full     (stkFull),
        .empty    (stkEmpty),
        .level    (stack_level)
    );
`else
    assign stack_level = '0;
`endif

    always_comb begin
        seqPc  = upc + ADDR_W'(1);
        nextPc = seqPc;
        errSet = 1'b0;
`ifdef UCODE_STACK_EN
        doPush = 1'b0;
        doPop  = 1'b0;
`endif
        case (mode)
            SEQ:      nextPc = seqPc;
            JUMP:     nextPc = target;
            BRANCH:   nextPc = cond_true ? target : seqPc;
            DISPATCH: nextPc = target + ADDR_W'(dispIdx);
`ifdef UCODE_STACK_EN
            CALL: begin
                nextPc = target;
                doPush = 1'b1;
                errSet = stkFull;
            end
            RETURN: begin
                if (stkEmpty) begin
                    nextPc = '0;
                    errSet = 1'b1;
                end else begin
                    nextPc = stkTop;
                    doPop  = 1'b1;
                end
            end
`else
            CALL:     nextPc = target;
            RETURN: begin
                nextPc = '0;
                errSet = 1'b1;
            end
`endif
            FETCH:    nextPc = '0;
            default: begin
                nextPc = '0;
                errSet = 1'b1;
            end
        endcase
    end

    // Stage p1: address advance and registered microword fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upc     <= '0;
            ctrl_p1 <= '0;
            mode_p1 <= SEQ;
            seq_err <= 1'b0;
        end else if (!stall) begin
            upc     <= nextPc;
            ctrl_p1 <= uword[MODE_W+ADDR_W +: CTRL_W];
            mode_p1 <= mode;
            if (errSet) begin
                seq_err <= 1'b1;
            end
        end
    end

    assign ctrl       = ctrl_p1;
    assign instr_done = (mode_p1 == FETCH);

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: a cycle-by-cycle vector table plus
// hand-written sequences for stack overflow, stall and asynchronous reset.
module tb_ucode_sequencer;

    localparam int AW = 6;
    localparam int CW = 16;
    localparam int SD = 4;
    localparam int LW = $clog2(SD + 1);
`ifdef UCODE_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    localparam logic [2:0] M_SEQ = 3'd0, M_JMP = 3'd1, M_BR = 3'd2, M_DSP = 3'd3;
    localparam logic [2:0] M_CALL = 3'd4, M_RET = 3'd5, M_FET = 3'd6, M_RSV = 3'd7;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              stall = 1'b0;
    logic              cond_true = 1'b0;
    logic [1:0]        op = '0;
    logic [5:0]        funct = '0;
    logic [AW-1:0]     uaddr;
    logic [CW+AW+2:0]  uword = '0;
    logic [CW-1:0]     ctrl;
    logic              instr_done;
    logic              seq_err;
    logic [LW-1:0]     stack_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ucode_sequencer #(
        .ADDR_W      (AW),
        .CTRL_W      (CW),
        .STACK_DEPTH (SD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .op          (op),
        .funct       (funct),
        .cond_true   (cond_true),
        .uaddr       (uaddr),
        .uword       (uword),
        .ctrl        (ctrl),
        .instr_done  (instr_done),
        .seq_err     (seq_err),
        .stack_level (stack_level)
    );

    typedef struct {
        logic [2:0]  m;
        logic [5:0]  t;
        logic [15:0] c;
        logic [1:0]  o;
        logic [5:0]  f;
        logic        cd;
        logic        s;
        logic [5:0]  eA;
        logic [15:0] eC;
        logic        eD;
        logic [2:0]  eL;
        logic        eE;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [2:0] m, input logic [5:0] t, input logic [15:0] c,
                       input logic [1:0] o, input logic [5:0] f, input logic cd, input logic s,
                       input logic [5:0] eA, input logic [15:0] eC, input logic eD,
                       input logic [2:0] eL, input logic eE);
        vec_t v;
        v.m = m; v.t = t; v.c = c; v.o = o; v.f = f; v.cd = cd; v.s = s;
        v.eA = eA; v.eC = eC; v.eD = eD; v.eL = eL; v.eE = eE;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] m, input logic [5:0] t, input logic [15:0] c,
                        input logic [1:0] o, input logic [5:0] f, input logic cd, input logic s);
        uword = {c, t, m};
        op = o; funct = f; cond_true = cd; stall = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chkAll(input string tag, input logic [5:0] eA, input logic [15:0] eC,
                          input logic [2:0] eL, input logic eE);
        chk({tag, " uaddr"}, 32'(uaddr), 32'(eA));
        chk({tag, " ctrl"}, 32'(ctrl), 32'(eC));
        chk({tag, " level"}, 32'(stack_level), 32'(eL));
        chk({tag, " seq_err"}, 32'(seq_err), 32'(eE));
    endtask

    task automatic pulseReset();
        #2 reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    initial begin
        add(M_SEQ, 0, 16'h1111, 0, 0, 0, 0,  1, 16'h1111, 0, 0, 0);
        add(M_SEQ, 0, 16'h2222, 0, 0, 0, 0,  2, 16'h2222, 0, 0, 0);
        add(M_SEQ, 0, 16'h3333, 0, 0, 0, 0,  3, 16'h3333, 0, 0, 0);
        add(M_SEQ, 0, 16'h4444, 0, 0, 0, 1,  3, 16'h3333, 0, 0, 0);
        add(M_SEQ, 0, 16'h4444, 0, 0, 0, 1,  3, 16'h3333, 0, 0, 0);
        add(M_SEQ, 0, 16'h4444, 0, 0, 0, 1,  3, 16'h3333, 0, 0, 0);
        add(M_SEQ, 0, 16'h4444, 0, 0, 0, 0,  4, 16'h4444, 0, 0, 0);
        add(M_JMP, 5, 16'h5555, 0, 0, 0, 0,  5, 16'h5555, 0, 0, 0);
        add(M_BR, 20, 16'h0606, 0, 0, 1, 0, 20, 16'h0606, 0, 0, 0);
        add(M_JMP, 5, 16'h0707, 0, 0, 0, 0,  5, 16'h0707, 0, 0, 0);
        add(M_BR, 20, 16'h0808, 0, 0, 0, 0,  6, 16'h0808, 0, 0, 0);
        add(M_JMP, 0, 16'h0909, 0, 0, 0, 0,  0, 16'h0909, 0, 0, 0);
        add(M_DSP, 8, 16'h0A0A, 2'b01, 6'b100001, 0, 0, 33, 16'h0A0A, 0, 0, 0);
        add(M_DSP, 60, 16'h0B0B, 2'b11, 6'b111111, 0, 0, 59, 16'h0B0B, 0, 0, 0);
        add(M_JMP, 63, 16'h0C0C, 0, 0, 0, 0, 63, 16'h0C0C, 0, 0, 0);
        add(M_SEQ, 0, 16'h0D0D, 0, 0, 0, 0,  0, 16'h0D0D, 0, 0, 0);
        add(M_FET, 0, 16'h0E0E, 0, 0, 0, 0,  0, 16'h0E0E, 1, 0, 0);
        add(M_JMP, 3, 16'h0F0F, 0, 0, 0, 0,  3, 16'h0F0F, 0, 0, 0);
`ifdef UCODE_STACK_EN
        add(M_CALL, 10, 16'h1010, 0, 0, 0, 0, 10, 16'h1010, 0, 1, 0);
        add(M_RET, 0, 16'h1111, 0, 0, 0, 0,    4, 16'h1111, 0, 0, 0);
        add(M_RET, 0, 16'h1212, 0, 0, 0, 0,    0, 16'h1212, 0, 0, 1);
`else
        add(M_CALL, 10, 16'h1010, 0, 0, 0, 0, 10, 16'h1010, 0, 0, 0);
        add(M_RET, 0, 16'h1111, 0, 0, 0, 0,    0, 16'h1111, 0, 0, 1);
        add(M_SEQ, 0, 16'h1212, 0, 0, 0, 0,    1, 16'h1212, 0, 0, 1);
`endif

        #1;
        chkAll("reset", 0, 0, 0, 0);
        chk("reset done", 32'(instr_done), 32'd0);
        #1 reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].m, vecs[i].t, vecs[i].c, vecs[i].o, vecs[i].f, vecs[i].cd, vecs[i].s);
            chkAll($sformatf("v%0d", i), vecs[i].eA, vecs[i].eC, vecs[i].eL, vecs[i].eE);
            chk($sformatf("v%0d done", i), 32'(instr_done), 32'(vecs[i].eD));
        end

        // Nested calls past the stack depth, with a stalled reserved word in between.
        pulseReset();
        step(M_CALL, 10, 16'hC001, 0, 0, 0, 0);
        chkAll("call1", 10, 16'hC001, STK ? 3'd1 : 3'd0, 0);
        step(M_CALL, 10, 16'hC002, 0, 0, 0, 0);
        chkAll("call2", 10, 16'hC002, STK ? 3'd2 : 3'd0, 0);
        step(M_RSV, 0, 16'hDEAD, 0, 0, 0, 1);
        chkAll("stall rsvd", 10, 16'hC002, STK ? 3'd2 : 3'd0, 0);
        step(M_CALL, 10, 16'hC003, 0, 0, 0, 0);
        chkAll("call3", 10, 16'hC003, STK ? 3'd3 : 3'd0, 0);
        step(M_CALL, 10, 16'hC004, 0, 0, 0, 0);
        chkAll("call4", 10, 16'hC004, STK ? 3'd4 : 3'd0, 0);
        step(M_CALL, 10, 16'hC005, 0, 0, 0, 0);
        chkAll("call5 overflow", 10, 16'hC005, STK ? 3'd4 : 3'd0, STK);
        step(M_RET, 0, 16'hC006, 0, 0, 0, 0);
        chkAll("ret after overflow", STK ? 6'd11 : 6'd0, 16'hC006, STK ? 3'd3 : 3'd0, 1);

        // Asynchronous reset between edges while inside a subroutine.
        step(M_CALL, 10, 16'hC007, 0, 0, 0, 0);
        chkAll("call before reset", 10, 16'hC007, STK ? 3'd4 : 3'd0, 1);
        #2 reset = 1'b1;
        #1;
        chkAll("async reset", 0, 0, 0, 0);
        chk("async reset done", 32'(instr_done), 32'd0);
        #1 reset = 1'b0;
        step(M_SEQ, 0, 16'hBEEF, 0, 0, 0, 0);
        chkAll("post reset seq", 1, 16'hBEEF, 0, 0);
        step(M_RET, 0, 16'hCAFE, 0, 0, 0, 0);
        chkAll("ret on cleared stack", 0, 16'hCAFE, 0, 1);

        // Reserved mode behaves as FETCH and flags an error.
        pulseReset();
        step(M_JMP, 40, 16'h4040, 0, 0, 0, 0);
        chkAll("jump 40", 40, 16'h4040, 0, 0);
        step(M_RSV, 12, 16'h7777, 0, 0, 0, 0);
        chkAll("reserved", 0, 16'h7777, 0, 1);
        step(M_SEQ, 0, 16'h8888, 0, 0, 0, 0);
        chkAll("err sticky", 1, 16'h8888, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
